// File: rtl/fifo_pkg.sv
// ============================================================================
//  fifo_pkg : shared FSM encoding, pointer width and pointer helper for fifo_ctrl
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int PTR_W = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_RESET  = 3'd0;
   localparam state_t ST_INIT   = 3'd1;
   localparam state_t ST_IDLE   = 3'd2;
   localparam state_t ST_ACTIVE = 3'd3;
   localparam state_t ST_ERROR  = 3'd4;

   // Depth need not be a power of two, so wrap explicitly at len-1.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                input int unsigned       len);
      if (ptr == PTR_W'(len - 1)) return '0;
      return ptr + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl_memory.sv
// ============================================================================
//  memory : simple dual-port word storage, synchronous write, registered read
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module memory #(
   parameter int MEM_WIDTH  = 10,
   parameter int MEM_LENGHT = 4,
   parameter int ADDR_W     = 2
) (
   input  logic                 clk,
   input  logic                 write_enable,
   input  logic                 read_enable,
   input  logic [ADDR_W-1:0]    write_addr,
   input  logic [ADDR_W-1:0]    read_addr,
   input  logic [MEM_WIDTH-1:0] data_in,
   output logic [MEM_WIDTH-1:0] data_out
);

   logic [MEM_WIDTH-1:0] r_mem [0:MEM_LENGHT-1];
   logic [MEM_WIDTH-1:0] r_data;

   // Read-before-write: a same-address write and read return the old word.
   always_ff @(posedge clk) begin
      if (write_enable) r_mem[write_addr] <= data_in;
      if (read_enable)  r_data <= r_mem[read_addr];
   end

   assign data_out = r_data;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
//  fifo_ctrl : FIFO push/pop controller with occupancy flags, sticky errors
//  Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int MEM_WIDTH  = 10,
   parameter int MEM_LENGHT = 4
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 init,
   input  logic [3:0]           umbral_alto,
   input  logic [3:0]           umbral_bajo,
   input  logic                 push,
   input  logic                 pop,
   input  logic [MEM_WIDTH-1:0] Fifo_Data_in,
   output logic [MEM_WIDTH-1:0] Fifo_Data_out,
   output logic                 valid_out,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow,
   output logic                 underflow,
   output logic [2:0]           state
);

   localparam int c_CW = $clog2(MEM_LENGHT) + 1;
   localparam int c_AW = $clog2(MEM_LENGHT);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [c_CW-1:0]    r_count;
   logic [c_CW-1:0]    w_count_nxt;
   logic [4:0]         w_cnt5;
   logic [3:0]         r_alto;
   logic [3:0]         r_bajo;
   logic [3:0]         w_alto_nxt;
   logic [3:0]         w_bajo_nxt;
   logic               r_full;
   logic               r_empty;
   logic               r_almost_full;
   logic               r_almost_empty;
   logic               r_overflow;
   logic               r_underflow;
   logic               r_valid;
   logic               w_run;
   logic               w_clear;
   logic               w_read_en;
   logic               w_write_en;
   logic               w_ovf_ev;
   logic               w_unf_ev;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) r_state <= ST_RESET;
      else          r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_RESET:  w_state_nxt = ST_INIT;
         ST_INIT:   w_state_nxt = init ? ST_INIT : ST_IDLE;
         ST_IDLE: begin
            if (w_ovf_ev || w_unf_ev) w_state_nxt = ST_ERROR;
            else if (w_write_en)      w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (w_ovf_ev || w_unf_ev)  w_state_nxt = ST_ERROR;
            else if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
         end
         ST_ERROR:  w_state_nxt = ST_ERROR;
         default:   w_state_nxt = ST_RESET;
      endcase
      if (init) w_state_nxt = ST_INIT;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      state   = r_state;
      w_run   = !init && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE) ||
                          (r_state == ST_ERROR));
      w_clear = init || (r_state == ST_INIT) || (r_state == ST_RESET);
   end

   // Request qualification; a pop frees a slot so a push at full still lands.
   assign w_read_en  = w_run && pop && !r_empty;
   assign w_write_en = w_run && push && (!r_full || w_read_en);
   assign w_ovf_ev   = w_run && push && !w_write_en;
   assign w_unf_ev   = w_run && pop && r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_clear)
         w_count_nxt = '0;
      else if (w_write_en && !w_read_en)
         w_count_nxt = r_count + 1'b1;
      else if (!w_write_en && w_read_en)
         w_count_nxt = r_count - 1'b1;
   end

   assign w_cnt5     = 5'(w_count_nxt);
   assign w_alto_nxt = init ? umbral_alto : r_alto;
   assign w_bajo_nxt = init ? umbral_bajo : r_bajo;

   // Flags are registered from the next count so they move on the causing edge.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_alto         <= '0;
         r_bajo         <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b0;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
         r_valid        <= 1'b0;
      end else begin
         r_alto         <= w_alto_nxt;
         r_bajo         <= w_bajo_nxt;
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == c_CW'(MEM_LENGHT));
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_cnt5 >= {1'b0, w_alto_nxt});
         r_almost_empty <= (w_cnt5 <= {1'b0, w_bajo_nxt}) && (w_count_nxt != '0);
         r_valid        <= w_read_en;
         if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (w_write_en) r_wr_ptr <= ptr_inc(r_wr_ptr, MEM_LENGHT);
            if (w_read_en)  r_rd_ptr <= ptr_inc(r_rd_ptr, MEM_LENGHT);
            r_overflow  <= r_overflow  | w_ovf_ev;
            r_underflow <= r_underflow | w_unf_ev;
         end
      end
   end

   memory #(
      .MEM_WIDTH  (MEM_WIDTH),
      .MEM_LENGHT (MEM_LENGHT),
      .ADDR_W     (c_AW)
   ) u_memory (
      .clk          (clk),
      .write_enable (w_write_en),
      .read_enable  (w_read_en),
      .write_addr   (r_wr_ptr[c_AW-1:0]),
      .read_addr    (r_rd_ptr[c_AW-1:0]),
      .data_in      (Fifo_Data_in),
      .data_out     (Fifo_Data_out)
   );

   assign valid_out    = r_valid;
   assign full         = r_full;
   assign empty        = r_empty;
   assign almost_full  = r_almost_full;
   assign almost_empty = r_almost_empty;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
//  tb_fifo_ctrl : scoreboard bench for fifo_ctrl (depth 4, width 10)
//  Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;
   import fifo_pkg::*;

   localparam int W = 10;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         reset_L = 1'b0;
   logic         init = 1'b0;
   logic [3:0]   umbral_alto = '0;
   logic [3:0]   umbral_bajo = '0;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   logic [W-1:0] Fifo_Data_in = '0;
   logic [W-1:0] Fifo_Data_out;
   logic         valid_out, full, empty, almost_full, almost_empty;
   logic         overflow, underflow;
   logic [2:0]   state;

   fifo_ctrl #(.MEM_WIDTH(W), .MEM_LENGHT(L)) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .init          (init),
      .umbral_alto   (umbral_alto),
      .umbral_bajo   (umbral_bajo),
      .push          (push),
      .pop           (pop),
      .Fifo_Data_in  (Fifo_Data_in),
      .Fifo_Data_out (Fifo_Data_out),
      .valid_out     (valid_out),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .overflow      (overflow),
      .underflow     (underflow),
      .state         (state)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [W-1:0] model_q[$];
   logic [W-1:0] exp_q[$];
   int           m_count = 0;
   bit           got_pop = 1'b0;

   // Drives one cycle of push/pop and advances the reference model.
   task automatic step(input bit p, input bit q, input logic [W-1:0] d);
      bit rd, wr;
      rd = q && (m_count != 0);
      wr = p && ((m_count != L) || rd);
      push = p; pop = q; Fifo_Data_in = d;
      got_pop = rd;
      if (rd) exp_q.push_back(model_q.pop_front());
      if (wr) model_q.push_back(d);
      m_count = m_count + int'(wr) - int'(rd);
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic model_reset();
      model_q.delete(); exp_q.delete(); m_count = 0; got_pop = 1'b0;
   endtask

   task automatic do_init(input logic [3:0] alto, input logic [3:0] bajo);
      init = 1'b1; umbral_alto = alto; umbral_bajo = bajo;
      @(posedge clk); #1;
      init = 1'b0;
      @(posedge clk); #1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [9:0] got, expv;
      reset_L = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got  = {full, empty, almost_full, almost_empty, overflow, underflow, valid_out, state};
      expv = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_RESET};
      n_checks++;
      if (got !== expv) begin
         n_errors++; $display("FAIL reset_outputs: got %b, expected %b", got, expv);
      end
      reset_L = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (state !== ST_INIT) begin
         n_errors++; $display("FAIL reset_to_init: state=%0d, expected %0d", state, ST_INIT);
      end
      do_init(4'd3, 4'd1);
      n_checks++;
      if (state !== ST_IDLE || empty !== 1'b1) begin
         n_errors++; $display("FAIL init_to_idle: state=%0d empty=%0b, expected %0d/1", state, empty, ST_IDLE);
      end
   endtask

   task automatic test_fill();
      logic [5:0] got, expv;
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 1'b0, W'(i));
         got  = {full, almost_full, almost_empty, empty, overflow, underflow};
         expv = {i == 4, i >= 3, i == 1, 1'b0, 1'b0, 1'b0};
         n_checks++;
         if (got !== expv || state !== ST_ACTIVE) begin
            n_errors++;
            $display("FAIL fill_flags[%0d]: flags=%b state=%0d, expected %b state=%0d", i, got, state, expv, ST_ACTIVE);
         end
      end
   endtask

   task automatic test_drain();
      logic [W-1:0] e;
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, '0);
         if (got_pop) begin
            e = exp_q.pop_front();
            n_checks++;
            if (valid_out !== 1'b1 || Fifo_Data_out !== e) begin
               n_errors++; $display("FAIL drain_data[%0d]: valid=%0b data=%h, expected 1/%h", i, valid_out, Fifo_Data_out, e);
            end
         end
         n_checks++;
         if (empty !== (i == 4) || full !== 1'b0 || state !== ((i == 4) ? ST_IDLE : ST_ACTIVE)) begin
            n_errors++; $display("FAIL drain_flags[%0d]: empty=%0b full=%0b state=%0d", i, empty, full, state);
         end
      end
      step(1'b0, 1'b0, '0);
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_errors++; $display("FAIL valid_pulse: valid=%0b, expected 0", valid_out);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] e;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 9; i++) begin
            if (i < 6) step(1'b1, i >= 3, W'(10'h100 + r * 16 + i));
            else       step(1'b0, 1'b1, '0);
            if (got_pop) begin
               e = exp_q.pop_front();
               n_checks++;
               if (valid_out !== 1'b1 || Fifo_Data_out !== e) begin
                  n_errors++; $display("FAIL wrap_data[%0d.%0d]: valid=%0b data=%h, expected 1/%h", r, i, valid_out, Fifo_Data_out, e);
               end
            end
            n_checks++;
            if (full !== 1'b0 || overflow !== 1'b0) begin
               n_errors++; $display("FAIL wrap_occupancy[%0d.%0d]: full=%0b overflow=%0b, expected 0/0", r, i, full, overflow);
            end
         end
      end
      n_checks++;
      if (state !== ST_IDLE || empty !== 1'b1) begin
         n_errors++; $display("FAIL wrap_end: state=%0d empty=%0b, expected %0d/1", state, empty, ST_IDLE);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] e;
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, W'(10'h010 + i));
      step(1'b1, 1'b0, 10'h3FF);
      n_checks++;
      if (overflow !== 1'b1 || full !== 1'b1 || state !== ST_ERROR || underflow !== 1'b0) begin
         n_errors++; $display("FAIL overflow_set: ovf=%0b full=%0b state=%0d unf=%0b, expected 1/1/%0d/0", overflow, full, state, underflow, ST_ERROR);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, '0);
         e = exp_q.pop_front();
         n_checks++;
         if (valid_out !== 1'b1 || Fifo_Data_out !== e || state !== ST_ERROR || overflow !== 1'b1) begin
            n_errors++; $display("FAIL overflow_drain[%0d]: valid=%0b data=%h state=%0d ovf=%0b, expected 1/%h/%0d/1", i, valid_out, Fifo_Data_out, state, overflow, e, ST_ERROR);
         end
      end
      init = 1'b1; umbral_alto = 4'd3; umbral_bajo = 4'd1;
      @(posedge clk); #1;
      init = 1'b0;
      n_checks++;
      if (state !== ST_INIT || overflow !== 1'b0) begin
         n_errors++; $display("FAIL overflow_init: state=%0d ovf=%0b, expected %0d/0", state, overflow, ST_INIT);
      end
      @(posedge clk); #1;
      model_reset();
      n_checks++;
      if (state !== ST_IDLE) begin
         n_errors++; $display("FAIL overflow_idle: state=%0d, expected %0d", state, ST_IDLE);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] e;
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, W'(10'h020 + i));
      step(1'b1, 1'b1, 10'h025);
      e = exp_q.pop_front();
      n_checks++;
      if (full !== 1'b1 || overflow !== 1'b0 || valid_out !== 1'b1 || Fifo_Data_out !== e) begin
         n_errors++; $display("FAIL full_pushpop: full=%0b ovf=%0b valid=%0b data=%h, expected 1/0/1/%h", full, overflow, valid_out, Fifo_Data_out, e);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 1'b1, '0);
         e = exp_q.pop_front();
         n_checks++;
         if (valid_out !== 1'b1 || Fifo_Data_out !== e) begin
            n_errors++; $display("FAIL b2b_drain[%0d]: valid=%0b data=%h, expected 1/%h", i, valid_out, Fifo_Data_out, e);
         end
      end
      step(1'b1, 1'b1, 10'h026);
      n_checks++;
      if (underflow !== 1'b1 || empty !== 1'b0 || valid_out !== 1'b0 || state !== ST_ERROR || almost_empty !== 1'b1) begin
         n_errors++; $display("FAIL empty_pushpop: unf=%0b empty=%0b valid=%0b state=%0d ae=%0b, expected 1/0/0/%0d/1", underflow, empty, valid_out, state, almost_empty, ST_ERROR);
      end
      step(1'b0, 1'b1, '0);
      e = exp_q.pop_front();
      n_checks++;
      if (valid_out !== 1'b1 || Fifo_Data_out !== e || empty !== 1'b1 || underflow !== 1'b1) begin
         n_errors++; $display("FAIL error_service: valid=%0b data=%h empty=%0b unf=%0b, expected 1/%h/1/1", valid_out, Fifo_Data_out, empty, underflow, e);
      end
      do_init(4'd3, 4'd1);
   endtask

   task automatic test_async_reset();
      logic [9:0] got, expv;
      step(1'b1, 1'b0, 10'h031);
      step(1'b1, 1'b0, 10'h032);
      #2 reset_L = 1'b0;
      #1;
      got  = {full, empty, almost_full, almost_empty, overflow, underflow, valid_out, state};
      expv = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ST_RESET};
      n_checks++;
      if (got !== expv) begin
         n_errors++; $display("FAIL async_reset: got %b, expected %b", got, expv);
      end
      @(negedge clk);
      reset_L = 1'b1;
      @(posedge clk); #1;
      model_reset();
      do_init(4'd3, 4'd1);
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (valid_out !== 1'b0 || empty !== 1'b1 || underflow !== 1'b1) begin
         n_errors++; $display("FAIL post_reset_pop: valid=%0b empty=%0b unf=%0b, expected 0/1/1", valid_out, empty, underflow);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_overflow();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
